uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with an input FIFO, configurable frame format
//   (data bits, parity, stop bits) and internal baud divider. Sits between the
//   CPU peripheral bus and the board UART_TX pin.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frames (start, data LSB-first, optional
// parity, 1-2 stop bits) stream back-to-back while the FIFO holds data and enable is high.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          UART_TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          cnt;
  logic                 push, pop;
  logic [CW-1:0]        baud, baud_d;
  logic [3:0]           bit_idx, bit_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par, par_d, line_d, done_d, baud_wrap;

  // Full is taken from the registered count, so a pop in the same cycle does not free a slot.
  assign tx_ready  = (cnt != (AW+1)'(FIFO_DEPTH));
  assign push      = tx_valid && tx_ready;
  assign fifo_cnt  = cnt;
  assign baud_wrap = (baud == CW'(CLKS_PER_BIT-1));

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud;
    bit_d   = bit_idx;
    shreg_d = shreg;
    par_d   = par;
    pop     = 1'b0;
    done_d  = 1'b0;
    line_d  = 1'b1;
    if (state != IDLE) baud_d = baud_wrap ? '0 : baud + 1'b1;
    case (state)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (enable && cnt != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (baud_wrap) state_d = DATA;
      end
      DATA: begin
        line_d = shreg[0];
        if (baud_wrap) begin
          shreg_d = shreg >> 1;
          if (bit_idx == 4'(DATA_BITS-1)) begin
            bit_d = '0;
            if (PARITY != 0) state_d = PAR;
            else             state_d = STOP;
          end else begin
            bit_d = bit_idx + 1'b1;
          end
        end
      end
      PAR: begin
        line_d = par;
        if (baud_wrap) state_d = STOP;
      end
      STOP: begin
        // bit_idx counts stop bits here; the next frame starts with no idle gap.
        if (baud_wrap) begin
          if (bit_idx == 4'(STOP_BITS-1)) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (enable && cnt != '0) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shreg_d = mem[rd_ptr];
      par_d   = (PARITY == 2) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
    end
  end

  // Line, busy and done are registered together so they stay cycle-aligned.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      UART_TX <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_d;
      shreg   <= shreg_d;
      par     <= par_d;
      UART_TX <= line_d;
      busy    <= (state != IDLE);
      tx_done <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four frame formats checked bit-by-bit from a vector table,
// plus FIFO-full/back-to-back, mid-frame reset and enable-drop sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  logic       sysclk, reset, enable;
  logic [7:0] tx_data;
  logic [3:0] vld, ready_v, busy_v, done_v, line_v;
  logic [3:0][2:0] cnt_v;

  int checks = 0;
  int failures = 0;

  // k=0: 8N1, k=1: 8E1, k=2: 8O1, k=3: 7N2; all 4 clocks per bit, depth 4
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .sysclk(sysclk), .reset(reset), .enable(enable), .tx_data(tx_data), .tx_valid(vld[0]),
    .tx_ready(ready_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .fifo_cnt(cnt_v[0]), .UART_TX(line_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .sysclk(sysclk), .reset(reset), .enable(enable), .tx_data(tx_data), .tx_valid(vld[1]),
    .tx_ready(ready_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .fifo_cnt(cnt_v[1]), .UART_TX(line_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .sysclk(sysclk), .reset(reset), .enable(enable), .tx_data(tx_data), .tx_valid(vld[2]),
    .tx_ready(ready_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .fifo_cnt(cnt_v[2]), .UART_TX(line_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .sysclk(sysclk), .reset(reset), .enable(enable), .tx_data(tx_data[6:0]), .tx_valid(vld[3]),
    .tx_ready(ready_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .fifo_cnt(cnt_v[3]), .UART_TX(line_v[3]));

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic [0:11] seq;   // line value per bit period, first bit leftmost
    int         nb;
    int         len;
    string      nm;
  } vec_t;

  vec_t vt[8];

  logic lg_ln[256], lg_bz[256], lg_dn[256];
  int   log_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
    if (log_n < 256) begin
      lg_ln[log_n] = line_v[0];
      lg_bz[log_n] = busy_v[0];
      lg_dn[log_n] = done_v[0];
      log_n++;
    end
  endtask

  // Push one word into an idle, empty instance and check the whole frame.
  task automatic run_frame(input int k, input logic [7:0] d, input logic [0:11] seq,
                           input int nb, input int len, input string nm);
    logic ln[64];
    int dc, dpos, bl;
    dc = 0; dpos = -1; bl = 0;
    tx_data = d;
    vld[k]  = 1'b1;
    @(negedge sysclk);
    vld[k]  = 1'b0;
    @(negedge sysclk);
    chk($sformatf("%s_pre_start", nm), line_v[k], 1'b1);
    for (int c = 0; c < len; c++) begin
      @(negedge sysclk);
      ln[c] = line_v[k];
      if (done_v[k]) begin dc++; dpos = c; end
      if (!busy_v[k]) bl++;
    end
    for (int b = 0; b < nb; b++)
      chk($sformatf("%s_bit%0d", nm, b), ln[b*4+1], seq[b]);
    chk($sformatf("%s_first_cycle", nm), ln[0], 1'b0);
    chk($sformatf("%s_done_count", nm), dc, 1);
    chk($sformatf("%s_done_pos", nm), dpos, len-1);
    chk($sformatf("%s_busy_gaps", nm), bl, 0);
    @(negedge sysclk);
    chk($sformatf("%s_busy_after", nm), busy_v[k], 1'b0);
    chk($sformatf("%s_line_after", nm), line_v[k], 1'b1);
    chk($sformatf("%s_done_after", nm), done_v[k], 1'b0);
  endtask

  initial begin
    logic [7:0] words[5];
    logic [7:0] got;
    int s, guard, dc, gaps, lows;
    bit found;

    vt[0] = '{0, 8'hA5, 12'b0101001011_00, 10, 40, "8n1_a5"};
    vt[1] = '{0, 8'h3C, 12'b0001111001_00, 10, 40, "8n1_3c"};
    vt[2] = '{1, 8'h07, 12'b01110000011_0, 11, 44, "8e1_07"};
    vt[3] = '{1, 8'h80, 12'b00000000111_0, 11, 44, "8e1_80"};
    vt[4] = '{2, 8'h00, 12'b00000000011_0, 11, 44, "8o1_00"};
    vt[5] = '{2, 8'h01, 12'b01000000001_0, 11, 44, "8o1_01"};
    vt[6] = '{3, 8'h7F, 12'b0111111111_00, 10, 40, "7n2_7f"};
    vt[7] = '{3, 8'h2A, 12'b0010101011_00, 10, 40, "7n2_2a"};

    reset = 1'b0; enable = 1'b1; tx_data = '0; vld = '0; log_n = 0;
    #12;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_line%0d", k),  line_v[k], 1'b1);
      chk($sformatf("rst_busy%0d", k),  busy_v[k], 1'b0);
      chk($sformatf("rst_done%0d", k),  done_v[k], 1'b0);
      chk($sformatf("rst_cnt%0d", k),   cnt_v[k], 3'd0);
      chk($sformatf("rst_ready%0d", k), ready_v[k], 1'b1);
    end
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);

    for (int i = 0; i < 8; i++)
      run_frame(vt[i].k, vt[i].d, vt[i].seq, vt[i].nb, vt[i].len, vt[i].nm);

    // FIFO fill with enable low, then release and expect 5 gapless frames.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_data = words[i];
      vld[0]  = 1'b1;
      @(negedge sysclk);
    end
    chk("full_cnt", cnt_v[0], 3'd4);
    chk("full_ready", ready_v[0], 1'b0);
    repeat (3) @(negedge sysclk);
    chk("full_line_idle", line_v[0], 1'b1);
    chk("full_busy_idle", busy_v[0], 1'b0);
    enable = 1'b1;
    log_n = 0;
    tick();
    chk("full_push_refused", cnt_v[0], 3'd3);
    guard = 0;
    while (!ready_v[0] && guard < 10) begin tick(); guard++; end
    chk("full_ready_timeout", guard < 10, 1'b1);
    tick();
    vld[0] = 1'b0;
    chk("full_refill_cnt", cnt_v[0], 3'd4);
    while (log_n < 240) tick();
    s = -1;
    for (int i = 0; i < 20; i++) if (s < 0 && lg_ln[i] == 1'b0) s = i;
    chk("b2b_start", s, 1);
    if (s < 0) s = 1;
    dc = 0; gaps = 0;
    for (int i = s; i < s + 200; i++) begin
      if (lg_dn[i]) dc++;
      if (!lg_bz[i]) gaps++;
    end
    chk("b2b_done_count", dc, 5);
    chk("b2b_busy_gaps", gaps, 0);
    chk("b2b_busy_end", lg_bz[s+200], 1'b0);
    for (int f = 0; f < 5; f++) begin
      got = '0;
      for (int b = 0; b < 8; b++) got[b] = lg_ln[s + 40*f + 4*(b+1) + 1];
      chk($sformatf("b2b_start_bit%0d", f), lg_ln[s + 40*f + 1], 1'b0);
      chk($sformatf("b2b_byte%0d", f), got, words[f]);
    end
    chk("b2b_cnt_empty", cnt_v[0], 3'd0);

    // Reset in the middle of data bit 3 of 0xA5 (a 0 bit) with one word still queued.
    tx_data = 8'hA5; vld[0] = 1'b1;
    @(negedge sysclk);
    tx_data = 8'h0F;
    @(negedge sysclk);
    vld[0] = 1'b0;
    repeat (18) @(negedge sysclk);
    chk("rstmid_line_low", line_v[0], 1'b0);
    chk("rstmid_cnt_before", cnt_v[0], 3'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_line", line_v[0], 1'b1);
    chk("rstmid_cnt", cnt_v[0], 3'd0);
    chk("rstmid_busy", busy_v[0], 1'b0);
    chk("rstmid_ready", ready_v[0], 1'b1);
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    run_frame(0, 8'h3C, 12'b0001111001_00, 10, 40, "post_rst");

    // Drop enable during the first of two queued frames.
    tx_data = 8'h5A; vld[0] = 1'b1;
    @(negedge sysclk);
    tx_data = 8'hC3;
    @(negedge sysclk);
    vld[0] = 1'b0;
    repeat (10) @(negedge sysclk);
    enable = 1'b0;
    found = 1'b0; guard = 0;
    while (!found && guard < 60) begin
      @(negedge sysclk);
      if (done_v[0]) found = 1'b1;
      guard++;
    end
    chk("endrop_done_seen", found, 1'b1);
    repeat (2) @(negedge sysclk);
    chk("endrop_busy", busy_v[0], 1'b0);
    chk("endrop_line", line_v[0], 1'b1);
    chk("endrop_cnt", cnt_v[0], 3'd1);
    lows = 0;
    repeat (12) begin
      @(negedge sysclk);
      if (!line_v[0] || busy_v[0]) lows++;
    end
    chk("endrop_stays_idle", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
